radix4_booth_multiplier: RTL and testbench

RADIX4_BOOTH_MULTIPLIER -- requirements
Module: radix4_booth_multiplier

---
 rtl/rv32m_pkg.sv | 23 ++
 rtl/booth_encoder.sv | 32 +++
 rtl/radix4_booth_multiplier.sv | 155 +++++++++++++++
 tb/tb_radix4_booth_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// -----------------------------------------------------------------------------
// rv32m_pkg
// Shared types for the radix-4 Booth multiplier:
//   state_t     - control FSM states (IDLE, BUSY, DONE)
//   booth_sel_t - addend selection produced by the Booth window encoder
// -----------------------------------------------------------------------------
package rv32m_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO     = 3'd0,
        PLUS_M   = 3'd1,
        PLUS_2M  = 3'd2,
        MINUS_M  = 3'd3,
        MINUS_2M = 3'd4
    } booth_sel_t;

endpackage : rv32m_pkg

// File: rtl/booth_encoder.sv
// -----------------------------------------------------------------------------
// booth_encoder
// Purely combinational radix-4 Booth recoder. Maps the window
// {q[1], q[0], q[-1]} onto the addend selection for one iteration.
// Ports:
//   i_window [2:0] - Booth window {q[1], q[0], q[-1]}
//   o_sel          - selected addend (ZERO, +M, +2M, -M, -2M)
// -----------------------------------------------------------------------------
module booth_encoder
    import rv32m_pkg::*;
(
    input  logic [2:0] i_window,
    output booth_sel_t o_sel
);

    // Window-to-addend recoding table
    always_comb begin
        o_sel = ZERO;
        case (i_window)
            3'b000:  o_sel = ZERO;
            3'b001:  o_sel = PLUS_M;
            3'b010:  o_sel = PLUS_M;
            3'b011:  o_sel = PLUS_2M;
            3'b100:  o_sel = MINUS_2M;
            3'b101:  o_sel = MINUS_M;
            3'b110:  o_sel = MINUS_M;
            3'b111:  o_sel = ZERO;
            default: o_sel = ZERO;
        endcase
    end

endmodule : booth_encoder

// File: rtl/radix4_booth_multiplier.sv
// -----------------------------------------------------------------------------
// radix4_booth_multiplier
// Iterative radix-4 Booth multiplier: two multiplier bits retired per cycle,
// signed/unsigned selectable per operand (covers MUL/MULH/MULHSU/MULHU).
// Ports:
//   CLK                  - clock, all state on rising edge
//   RST                  - synchronous active-high reset
//   start                - one-cycle request; samples operands and sign flags
//   multiplicand_signed  - 1: operand A is two's complement
//   multiplier_signed    - 1: operand B is two's complement
//   multiplicand [N-1:0] - operand A
//   multiplier   [N-1:0] - operand B
//   product    [2N-1:0]  - full product, valid while finished=1
//   finished             - high from completion until next start or RST
// -----------------------------------------------------------------------------
module radix4_booth_multiplier
    import rv32m_pkg::*;
#(
    parameter int NUM_BITS = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic                    multiplicand_signed,
    input  logic                    multiplier_signed,
    input  logic [NUM_BITS-1:0]     multiplicand,
    input  logic [NUM_BITS-1:0]     multiplier,
    output logic [2*NUM_BITS-1:0]   product,
    output logic                    finished
);

    localparam int N        = NUM_BITS;
    localparam int ITERS    = (N + 2) / 2;
    localparam int CW       = $clog2(ITERS + 1);
    localparam int AW       = N + 4;          // accumulator width, holds +/-2M
    localparam int QW       = N + 2;          // extended multiplier width
    localparam int SW       = AW + QW + 1;    // {acc, q, q[-1]}
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITERS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t             r_state;
    state_t             w_next_state;
    logic [AW-1:0]      r_acc;
    logic [QW-1:0]      r_q;
    logic               r_qm1;
    logic [QW-1:0]      r_m;
    logic [CW-1:0]      r_count;
    logic [2*N-1:0]     r_product;
    logic               r_finished;

    booth_sel_t         w_sel;
    logic [AW-1:0]      w_m_ext;
    logic [AW-1:0]      w_m2;
    logic [AW-1:0]      w_operand;
    logic               w_cin;
    logic [AW-1:0]      w_sum;
    logic [SW-1:0]      w_comb;
    logic [SW-1:0]      w_shifted;

    booth_encoder u_booth_encoder (
        .i_window (({r_q[1:0], r_qm1})),
        .o_sel    (w_sel)
    );

    assign w_m_ext = {{2{r_m[QW-1]}}, r_m};
    assign w_m2    = {w_m_ext[AW-2:0], 1'b0};

    // Addend mux: subtraction is realised as inverted operand plus carry-in
    always_comb begin
        w_operand = {AW{1'b0}};
        w_cin     = 1'b0;
        case (w_sel)
            ZERO:     begin w_operand = {AW{1'b0}}; w_cin = 1'b0; end
            PLUS_M:   begin w_operand = w_m_ext;    w_cin = 1'b0; end
            PLUS_2M:  begin w_operand = w_m2;       w_cin = 1'b0; end
            MINUS_M:  begin w_operand = ~w_m_ext;   w_cin = 1'b1; end
            MINUS_2M: begin w_operand = ~w_m2;      w_cin = 1'b1; end
            default:  begin w_operand = {AW{1'b0}}; w_cin = 1'b0; end
        endcase
    end

    // The single accumulator adder
    assign w_sum     = r_acc + w_operand + {{(AW-1){1'b0}}, w_cin};
    assign w_comb    = {w_sum, r_q, r_qm1};
    assign w_shifted = SW'($signed(w_comb) >>> 2);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; start restarts from any state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = BUSY;
                else       w_next_state = IDLE;
            end
            BUSY: begin
                if (start)                    w_next_state = BUSY;
                else if (r_count == CNT_ZERO) w_next_state = DONE;
                else                          w_next_state = BUSY;
            end
            DONE: begin
                if (start) w_next_state = BUSY;
                else       w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand load, Booth iterations and result capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc      <= {AW{1'b0}};
            r_q        <= {QW{1'b0}};
            r_qm1      <= 1'b0;
            r_m        <= {QW{1'b0}};
            r_count    <= CNT_ZERO;
            r_product  <= {(2*N){1'b0}};
            r_finished <= 1'b0;
        end else if (start) begin
            r_acc      <= {AW{1'b0}};
            r_m        <= multiplicand_signed ? {{2{multiplicand[N-1]}}, multiplicand}
                                              : {2'b00, multiplicand};
            r_q        <= multiplier_signed   ? {{2{multiplier[N-1]}}, multiplier}
                                              : {2'b00, multiplier};
            r_qm1      <= 1'b0;
            r_count    <= CNT_LOAD;
            r_finished <= 1'b0;
        end else if (r_state == BUSY && r_count != CNT_ZERO) begin
            r_acc   <= w_shifted[SW-1 -: AW];
            r_q     <= w_shifted[QW:1];
            r_qm1   <= w_shifted[0];
            r_count <= r_count - CNT_ONE;
        end else if (r_state == BUSY) begin
            // All windows consumed: low 2N bits of {acc, q} hold the product
            r_product  <= {r_acc[N-3:0], r_q};
            r_finished <= 1'b1;
        end else begin
            r_product  <= r_product;
            r_finished <= r_finished;
        end
    end

    assign product  = r_product;
    assign finished = r_finished;

endmodule : radix4_booth_multiplier

// File: tb/tb_radix4_booth_multiplier.sv
module tb_radix4_booth_multiplier;
    import rv32m_pkg::*;

    localparam int N   = 32;
    localparam int LAT = 18;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          multiplicand_signed;
    logic          multiplier_signed;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic [2*N-1:0] product;
    logic          finished;

    int checks = 0;
    int errors = 0;

    radix4_booth_multiplier #(.NUM_BITS(N)) dut (
        .CLK                 (CLK),
        .RST                 (RST),
        .start               (start),
        .multiplicand_signed (multiplicand_signed),
        .multiplier_signed   (multiplier_signed),
        .multiplicand        (multiplicand),
        .multiplier          (multiplier),
        .product             (product),
        .finished            (finished)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          sa;
        logic          sb;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [63:0]   exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sa, input logic sb,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0]  ea;
        logic signed [65:0]  eb;
        logic signed [131:0] pr;
        ea = sa ? {{34{a[31]}}, a} : {34'd0, a};
        eb = sb ? {{34{b[31]}}, b} : {34'd0, b};
        pr = ea * eb;
        return pr[63:0];
    endfunction

    // Pulse start with the given operands; returns start-to-finished latency
    task automatic run_op(input logic sa, input logic sb, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] p, output int lat);
        @(negedge CLK);
        multiplicand_signed = sa;
        multiplier_signed   = sb;
        multiplicand        = a;
        multiplier          = b;
        start               = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!finished && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        p = product;
    endtask

    vec_t vecs[12];
    logic [63:0] p;
    logic [63:0] held;
    int lat;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB};
        vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        vecs[3]  = '{1'b1, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001};
        vecs[5]  = '{1'b0, 1'b0, 32'h00000000, 32'h12345678, 64'h00000000_00000000};
        vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000001};
        vecs[7]  = '{1'b1, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
        vecs[8]  = '{1'b1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC0000000_80000000};
        vecs[9]  = '{1'b0, 1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000};
        vecs[10] = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
        vecs[11] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 64'hC0000000_00000000};

        RST = 1'b1; start = 1'b0;
        multiplicand_signed = 1'b0; multiplier_signed = 1'b0;
        multiplicand = 32'd0; multiplier = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_finished", {63'd0, finished}, 64'd0);
        chk("reset_product", product, 64'd0);
        RST = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].sa, vecs[i].sb, vecs[i].a, vecs[i].b, p, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
        end

        // Product must hold in DONE while inputs move
        held = product;
        @(negedge CLK);
        multiplicand = 32'hDEADBEEF;
        multiplier   = 32'h12345678;
        multiplicand_signed = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("done_hold_product", product, vecs[11].exp);
        chk("done_hold_finished", {63'd0, finished}, 64'd1);

        // Start from DONE clears finished on the sampling edge
        @(negedge CLK);
        multiplicand_signed = 1'b0; multiplier_signed = 1'b0;
        multiplicand = 32'd3; multiplier = 32'd5; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("start_clears_finished", {63'd0, finished}, 64'd0);
        // Restart 6 cycles after the first start with 9*11
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        multiplicand = 32'd9; multiplier = 32'd11; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        lat = 0;
        while (!finished && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("restart_latency", 64'(lat), 64'(LAT));
        chk("restart_product", product, 64'h63);

        // Reset at BUSY cycle 10 discards the operation
        @(negedge CLK);
        multiplicand = 32'd1234; multiplier = 32'd5678; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_busy_finished", {63'd0, finished}, 64'd0);
        chk("rst_busy_state", {62'd0, dut.r_state}, {62'd0, IDLE});
        repeat (25) @(posedge CLK);
        #1;
        chk("rst_busy_stays_idle", {63'd0, finished}, 64'd0);
        run_op(1'b0, 1'b0, 32'd2, 32'd2, p, lat);
        chk("after_rst_latency", 64'(lat), 64'(LAT));
        chk("after_rst_product", p, 64'd4);

        // Random regression across all sign modes with corner operands mixed in
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] corners [5];
            logic        sa;
            logic        sb;
            corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            run_op(sa, sb, a, b, p, lat);
            chk($sformatf("rand%0d a=%h b=%h sa=%0d sb=%0d", i, a, b, sa, sb),
                {p[63:1], p[0] & (lat == LAT)} | {63'd0, (lat != LAT)},
                ref_mul(sa, sb, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_radix4_booth_multiplier
